pipeline_controller: RTL and testbench
======================================

// Module: pipeline_controller
// PURPOSE
//  Pipelined ARM control unit feeding the datapath: decodes InstrD[31:12] and carries control through E/M/W registers.
//  Holds the NZCV flag register and does conditional execution in E. Resolves branches in D (BranchTakenD).
//  Exports hazard hints (FlagStallD, PCWrPendingF, MemtoRegE, RegWriteM) to the hazard unit.
// PARAMETERS
//  none (fixed ARM subset: ADD/SUB/AND/ORR/CMP, LDR/STR imm, B)
// PORTS
//  clk           in   1   clock; all state updates on rising edge
//  reset         in   1   synchronous, active-high; clears all state
//  InstrD        in   20  InstrD[31:12]: Cond[31:28] Op[27:26] Funct[25:20] Rd[15:12]
//  ALUFlagsE     in   4   {N,Z,C,V} from the datapath ALU
//  FlushE        in   1   clear E control register (bubble)
//  RegSrcD       out  2   [0]=RA1 is R15 (branch); [1]=RA2 from Rd (STR)
//  ImmSrcD       out  2   00 DP imm8, 01 mem imm12, 10 branch imm24
//  BranchTakenD  out  1   B in D with condition passing against flags, not flag-stalled
//  FlagStallD    out  1   conditional B in D while the E instr may write flags
//  ALUSrcE       out  1   SrcB = ExtImmE
//  ALUControlE   out  2   00 ADD, 01 SUB, 10 AND, 11 ORR
//  MemWriteM     out  1   store enable
//  MemtoRegE     out  1   load in E (load-use detection)
//  RegWriteM     out  1   qualified reg write in M (forwarding)
//  MemtoRegW     out  1   result = ReadDataW
//  RegWriteW     out  1   register file write enable
//  PCSrcW        out  1   PC <= ResultW
//  PCWrPendingF  out  1   PCSrcD|PCSrcE|PCSrcM (PC write in flight)
// BEHAVIOUR
//  Decode (combinational, D):
//   Op=00 DP: I=Funct[5], cmd=Funct[4:1], S=Funct[0]. ADD 0100, SUB 0010, AND 0000, ORR 1100.
//     CMP 1010 -> SUB, no RegWrite, FlagWrite=11. Other cmd -> no writes.
//     FlagWrite[1] (NZ) = S; FlagWrite[0] (CV) = S & (ADD|SUB).
//   Op=01 mem: ALUSrc=1, ADD; Funct[0]=1 LDR (RegWrite, MemtoReg), else STR (MemWrite, RegSrc[1]).
//     Funct[3]=0 (U=0) -> SUB.
//   Op=10 B: RegSrc[0]=1, ImmSrc=10, no reg/mem writes. Op=11 -> all writes 0.
//   PCSrcD = RegWriteD & (Rd==4'hF).
//  Cond check (EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL): cond 1111 fails.
//   E: CondExE = check(CondE, FlagsQ). D: check(InstrD[31:28], FlagsQ).
//  FlagStallD = BranchD & cond!=1110 & (FlagWriteE!=0).
//  BranchTakenD = BranchD & condD_pass & ~FlagStallD.
//  E register: ALUSrc, ALUControl, RegWrite, MemWrite, MemtoReg, PCSrc, FlagWrite, Cond; 1-cycle D->E.
//  FlushE or reset: every E field 0 (Cond=0 too). FlushE has priority over new D data.
//  Flags: FlagsQ[3:2] <= ALUFlagsE[3:2] if CondExE&FlagWriteE[1]; [1:0] likewise with [0].
//  M register: RegWrite, MemWrite, PCSrc gated by CondExE; MemtoReg ungated.
//  W register: RegWrite, MemtoReg, PCSrc copied from M.
//  Latency: D decode -> E next cycle -> M -> W; each 1 cycle, no enables (E/M/W never stall).
//  Reset: all registers and FlagsQ = 0; all outputs 0 except decode-driven D outputs, which follow InstrD.
//  Simultaneous: flag update and a D cond check in the same cycle use the pre-update FlagsQ.
//   FlagStallD covers the hazard; do not forward unless the macro is defined.
// CONFIGURATION
//  CTRL_FLAG_FWD_EN defined: FlagStallD tied 0.
//   D cond check uses FlagsQ merged with ALUFlagsE per FlagWriteE bits when CondExE=1.
//   Branch after SUBS resolves with no bubble.
//  Undefined: stall behaviour above.
// TESTING
//  1 reset=1 two cycles -> all E/M/W outputs 0, FlagsQ=0, PCSrcW=0.
//  2 SUBS r1,r1,r1 (0xE0511001) -> ALUControlE=01, FlagWriteE=11.
//    ALUFlagsE=0100 -> FlagsQ=0100 next edge.
//  3 SUBS then BEQ (0x0A000002) in D -> FlagStallD=1 one cycle.
//    Next cycle BranchTakenD=1 (macro off); macro on -> BranchTakenD=1 immediately.
//  4 ADDNE r2,r0,#1 with Z=1 -> RegWriteM=0, RegWriteW=0 two cycles later.
//  5 LDR r3,[r0,#4] -> MemtoRegE=1, ALUSrcE=1, RegWriteW=1, MemtoRegW=1 at W.
//    MOV-like ADD to r15 -> PCWrPendingF=1 for 3 cycles, PCSrcW=1.
//  6 FlushE=1 with STR in D -> next cycle MemtoRegE=0, MemWriteM=0 following cycle.

Source files
------------

// File: rtl/pipeline_controller.sv
// rtl/pipeline_controller.sv - pipelined ARM-subset control unit with NZCV flags, D-stage branch resolution
// Optional macro CTRL_FLAG_FWD_EN: forward E-stage ALU flags into the D condition check (no flag stall).
module pipeline_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] InstrD,
    input  logic [3:0]  ALUFlagsE,
    input  logic        FlushE,
    output logic [1:0]  RegSrcD,
    output logic [1:0]  ImmSrcD,
    output logic        BranchTakenD,
    output logic        FlagStallD,
    output logic        ALUSrcE,
    output logic [1:0]  ALUControlE,
    output logic        MemWriteM,
    output logic        MemtoRegE,
    output logic        RegWriteM,
    output logic        MemtoRegW,
    output logic        RegWriteW,
    output logic        PCSrcW,
    output logic        PCWrPendingF
);

    logic [3:0] cond_d;
    logic [1:0] op_d;
    logic [5:0] funct_d;
    logic [3:0] rd_d;
    logic [3:0] cmd_d;
    logic       unused_rn;

    assign cond_d    = InstrD[19:16];
    assign op_d      = InstrD[15:14];
    assign funct_d   = InstrD[13:8];
    assign rd_d      = InstrD[3:0];
    assign cmd_d     = funct_d[4:1];
    assign unused_rn = ^InstrD[7:4];

    logic       alu_src_d, reg_write_d, mem_write_d, mem_to_reg_d, branch_d, pc_src_d;
    logic [1:0] alu_ctrl_d, flag_write_d;

    always_comb begin
        RegSrcD      = 2'b00;
        ImmSrcD      = 2'b00;
        alu_src_d    = 1'b0;
        alu_ctrl_d   = 2'b00;
        reg_write_d  = 1'b0;
        mem_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        flag_write_d = 2'b00;
        branch_d     = 1'b0;
        case (op_d)
            2'b00: begin
                alu_src_d = funct_d[5];
                case (cmd_d)
                    4'b0100: begin
                        alu_ctrl_d   = 2'b00;
                        reg_write_d  = 1'b1;
                        flag_write_d = {funct_d[0], funct_d[0]};
                    end
                    4'b0010: begin
                        alu_ctrl_d   = 2'b01;
                        reg_write_d  = 1'b1;
                        flag_write_d = {funct_d[0], funct_d[0]};
                    end
                    4'b0000: begin
                        alu_ctrl_d   = 2'b10;
                        reg_write_d  = 1'b1;
                        flag_write_d = {funct_d[0], 1'b0};
                    end
                    4'b1100: begin
                        alu_ctrl_d   = 2'b11;
                        reg_write_d  = 1'b1;
                        flag_write_d = {funct_d[0], 1'b0};
                    end
                    4'b1010: begin
                        alu_ctrl_d   = 2'b01;
                        flag_write_d = 2'b11;
                    end
                    default: ;
                endcase
            end
            2'b01: begin
                ImmSrcD    = 2'b01;
                alu_src_d  = 1'b1;
                alu_ctrl_d = funct_d[3] ? 2'b00 : 2'b01;
                if (funct_d[0]) begin
                    reg_write_d  = 1'b1;
                    mem_to_reg_d = 1'b1;
                end else begin
                    mem_write_d = 1'b1;
                    RegSrcD[1]  = 1'b1;
                end
            end
            2'b10: begin
                RegSrcD[0] = 1'b1;
                ImmSrcD    = 2'b10;
                alu_src_d  = 1'b1;
                branch_d   = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_src_d = reg_write_d & (rd_d == 4'hF);

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = ~z;
            4'b0010: cond_pass = cy;
            4'b0011: cond_pass = ~cy;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = ~n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = ~v;
            4'b1000: cond_pass = cy & ~z;
            4'b1001: cond_pass = ~cy | z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = ~z & (n == v);
            4'b1101: cond_pass = z | (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    logic       alu_src_e, reg_write_e, mem_write_e, mem_to_reg_e, pc_src_e;
    logic [1:0] alu_ctrl_e, flag_write_e;
    logic [3:0] cond_e;
    logic [3:0] flags_q;
    logic       cond_ex_e;

    assign cond_ex_e = cond_pass(cond_e, flags_q);

    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            alu_src_e    <= 1'b0;
            alu_ctrl_e   <= 2'b00;
            reg_write_e  <= 1'b0;
            mem_write_e  <= 1'b0;
            mem_to_reg_e <= 1'b0;
            pc_src_e     <= 1'b0;
            flag_write_e <= 2'b00;
            cond_e       <= 4'b0000;
        end else begin
            alu_src_e    <= alu_src_d;
            alu_ctrl_e   <= alu_ctrl_d;
            reg_write_e  <= reg_write_d;
            mem_write_e  <= mem_write_d;
            mem_to_reg_e <= mem_to_reg_d;
            pc_src_e     <= pc_src_d;
            flag_write_e <= flag_write_d;
            cond_e       <= cond_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else begin
            if (cond_ex_e && flag_write_e[1]) flags_q[3:2] <= ALUFlagsE[3:2];
            if (cond_ex_e && flag_write_e[0]) flags_q[1:0] <= ALUFlagsE[1:0];
        end
    end

    // D-stage condition evaluation: either committed flags (stall covers the hazard) or forwarded ones
    logic [3:0] flags_d;
`ifdef CTRL_FLAG_FWD_EN
    always_comb begin
        flags_d = flags_q;
        if (cond_ex_e && flag_write_e[1]) flags_d[3:2] = ALUFlagsE[3:2];
        if (cond_ex_e && flag_write_e[0]) flags_d[1:0] = ALUFlagsE[1:0];
    end
    assign FlagStallD = 1'b0;
`else
    assign flags_d    = flags_q;
    assign FlagStallD = branch_d & (cond_d != 4'b1110) & (flag_write_e != 2'b00);
`endif

    assign BranchTakenD = branch_d & cond_pass(cond_d, flags_d) & ~FlagStallD;

    logic pc_src_m, mem_to_reg_m;

    always_ff @(posedge clk) begin
        if (reset) begin
            RegWriteM    <= 1'b0;
            MemWriteM    <= 1'b0;
            pc_src_m     <= 1'b0;
            mem_to_reg_m <= 1'b0;
            RegWriteW    <= 1'b0;
            MemtoRegW    <= 1'b0;
            PCSrcW       <= 1'b0;
        end else begin
            RegWriteM    <= reg_write_e & cond_ex_e;
            MemWriteM    <= mem_write_e & cond_ex_e;
            pc_src_m     <= pc_src_e & cond_ex_e;
            mem_to_reg_m <= mem_to_reg_e;
            RegWriteW    <= RegWriteM;
            MemtoRegW    <= mem_to_reg_m;
            PCSrcW       <= pc_src_m;
        end
    end

    assign ALUSrcE      = alu_src_e;
    assign ALUControlE  = alu_ctrl_e;
    assign MemtoRegE    = mem_to_reg_e;
    assign PCWrPendingF = pc_src_d | pc_src_e | pc_src_m;

endmodule

// File: tb/tb_pipeline_controller.sv
// tb/tb_pipeline_controller.sv - directed self-checking bench for pipeline_controller
module tb_pipeline_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] InstrD;
    logic [3:0]  ALUFlagsE;
    logic        FlushE;
    logic [1:0]  RegSrcD, ImmSrcD, ALUControlE;
    logic        BranchTakenD, FlagStallD, ALUSrcE, MemWriteM, MemtoRegE, RegWriteM;
    logic        MemtoRegW, RegWriteW, PCSrcW, PCWrPendingF;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [19:0] NOP     = 20'hEC000;
    localparam logic [19:0] SUBS    = 20'hE0511;
    localparam logic [19:0] BEQ     = 20'h0A000;
    localparam logic [19:0] BNE     = 20'h1A000;
    localparam logic [19:0] B_AL    = 20'hEA000;
    localparam logic [19:0] ADDNE   = 20'h12802;
    localparam logic [19:0] ADDAL   = 20'hE2802;
    localparam logic [19:0] LDR     = 20'hE5903;
    localparam logic [19:0] LDR_NEG = 20'hE5103;
    localparam logic [19:0] ADD_PC  = 20'hE280F;
    localparam logic [19:0] STR     = 20'hE5803;

    always #5 clk = ~clk;

    pipeline_controller dut (
        .clk(clk), .reset(reset), .InstrD(InstrD), .ALUFlagsE(ALUFlagsE), .FlushE(FlushE),
        .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD), .BranchTakenD(BranchTakenD), .FlagStallD(FlagStallD),
        .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .MemWriteM(MemWriteM), .MemtoRegE(MemtoRegE),
        .RegWriteM(RegWriteM), .MemtoRegW(MemtoRegW), .RegWriteW(RegWriteW), .PCSrcW(PCSrcW),
        .PCWrPendingF(PCWrPendingF)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1; InstrD = NOP; ALUFlagsE = 4'b0000; FlushE = 1'b0;
        step(); step();
        check("rst ALUSrcE", ALUSrcE, 0);
        check("rst ALUControlE", ALUControlE, 0);
        check("rst MemtoRegE", MemtoRegE, 0);
        check("rst RegWriteM", RegWriteM, 0);
        check("rst MemWriteM", MemWriteM, 0);
        check("rst RegWriteW", RegWriteW, 0);
        check("rst MemtoRegW", MemtoRegW, 0);
        check("rst PCSrcW", PCSrcW, 0);
        check("rst PCWrPendingF", PCWrPendingF, 0);

        reset = 1'b0;
        // flags are zero: EQ fails, NE passes, AL always taken
        InstrD = BEQ; settle();
        check("rst flags BEQ", BranchTakenD, 0);
        check("B RegSrcD", RegSrcD, 2'b01);
        check("B ImmSrcD", ImmSrcD, 2'b10);
        InstrD = BNE; settle();
        check("rst flags BNE", BranchTakenD, 1);
        check("BNE no stall", FlagStallD, 0);

        // SUBS r1,r1,r1
        InstrD = SUBS; settle();
        check("SUBS RegSrcD", RegSrcD, 0);
        check("SUBS ImmSrcD", ImmSrcD, 0);
        step();
        check("SUBS ALUControlE", ALUControlE, 2'b01);
        check("SUBS ALUSrcE", ALUSrcE, 0);
        InstrD = BEQ; ALUFlagsE = 4'b0100; settle();
`ifdef CTRL_FLAG_FWD_EN
        check("BEQ fwd stall", FlagStallD, 0);
        check("BEQ fwd taken", BranchTakenD, 1);
`else
        check("BEQ stall", FlagStallD, 1);
        check("BEQ taken during stall", BranchTakenD, 0);
`endif
        InstrD = B_AL; settle();
        check("B AL no stall", FlagStallD, 0);
        check("B AL taken", BranchTakenD, 1);
        InstrD = BEQ; FlushE = 1'b1;
        step();
        FlushE = 1'b0; ALUFlagsE = 4'b0000; settle();
        check("BEQ stall cleared", FlagStallD, 0);
        check("BEQ taken after flags", BranchTakenD, 1);
        InstrD = BNE; settle();
        check("BNE after Z set", BranchTakenD, 0);

        // ADDNE with Z=1 is squashed, ADD AL behind it is not
        InstrD = ADDNE; settle();
        check("ADDNE BranchTakenD", BranchTakenD, 0);
        step();
        InstrD = ADDAL;
        step();
        check("ADDNE RegWriteM", RegWriteM, 0);
        InstrD = NOP;
        step();
        check("ADDNE RegWriteW", RegWriteW, 0);
        check("ADDAL RegWriteM", RegWriteM, 1);
        step();
        check("ADDAL RegWriteW", RegWriteW, 1);

        // LDR r3,[r0,#4]
        InstrD = LDR; settle();
        check("LDR ImmSrcD", ImmSrcD, 2'b01);
        check("LDR RegSrcD", RegSrcD, 2'b00);
        step();
        check("LDR MemtoRegE", MemtoRegE, 1);
        check("LDR ALUSrcE", ALUSrcE, 1);
        check("LDR ALUControlE", ALUControlE, 2'b00);
        InstrD = LDR_NEG;
        step();
        check("LDR RegWriteM", RegWriteM, 1);
        check("LDR U=0 ALUControlE", ALUControlE, 2'b01);
        InstrD = NOP;
        step();
        check("LDR RegWriteW", RegWriteW, 1);
        check("LDR MemtoRegW", MemtoRegW, 1);

        // ADD r15: PC write pending through D, E, M
        InstrD = ADD_PC; settle();
        check("PC pend D", PCWrPendingF, 1);
        step();
        InstrD = NOP; settle();
        check("PC pend E", PCWrPendingF, 1);
        step();
        check("PC pend M", PCWrPendingF, 1);
        check("PC PCSrcW early", PCSrcW, 0);
        step();
        check("PC pend done", PCWrPendingF, 0);
        check("PC PCSrcW", PCSrcW, 1);

        // STR flushed out of E, then an unflushed STR
        InstrD = STR; FlushE = 1'b1; settle();
        check("STR RegSrcD", RegSrcD, 2'b10);
        check("STR ImmSrcD", ImmSrcD, 2'b01);
        step();
        FlushE = 1'b0; InstrD = NOP;
        check("flush MemtoRegE", MemtoRegE, 0);
        check("flush ALUSrcE", ALUSrcE, 0);
        step();
        check("flush MemWriteM", MemWriteM, 0);
        InstrD = STR;
        step();
        InstrD = NOP;
        check("STR ALUSrcE", ALUSrcE, 1);
        step();
        check("STR MemWriteM", MemWriteM, 1);
        check("STR RegWriteM", RegWriteM, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
